// File: rtl/sync_fifo_byte_packer_if.sv
// sync_fifo_byte_packer_if: byte-stream input, FIFO write port and status bundle of the byte packer
interface sync_fifo_byte_packer_if #(parameter int DW = 16);
  logic          clk7_en;
  logic          clr;
  logic [7:0]    in_dat;
  logic          in_vld;
  logic          in_rdy;
  logic          flush;
  logic [DW-1:0] fifo_in;
  logic          fifo_wr_en;
  logic          fifo_full;
  logic          busy;
  logic [7:0]    ovf_cnt;
  modport master (
    input  clk7_en, clr, in_dat, in_vld, flush, fifo_full,
    output in_rdy, fifo_in, fifo_wr_en, busy, ovf_cnt
  );
  modport slave (
    output clk7_en, clr, in_dat, in_vld, flush, fifo_full,
    input  in_rdy, fifo_in, fifo_wr_en, busy, ovf_cnt
  );
endinterface

// File: rtl/sync_fifo_byte_packer.sv
// sync_fifo_byte_packer: big-endian byte-to-word packer feeding a FIFO write port; PACK_OVF_CNT_EN enables the dropped-byte counter
module sync_fifo_byte_packer #(
  parameter int         DW  = 16,
  parameter logic [7:0] PAD = 8'h00
) (
  input logic clk,
  input logic rst,
  sync_fifo_byte_packer_if.master bus
);
  localparam int NB = DW / 8;
  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);
  logic [DW-1:0] asm_q, asm_d, out_word_q, out_word_d, pad_word;
  logic [CW-1:0] bcnt_q, bcnt_d, bcnt_a;
  logic          out_vld_q, out_vld_d, flush_pend_q, flush_pend_d;
  logic          out_free, acc, do_flush;
  assign out_free       = !out_vld_q | !bus.fifo_full;
  assign bus.in_rdy     = !(flush_pend_q | (bcnt_q == LAST & !out_free));
  assign bus.fifo_in    = out_word_q;
  assign bus.fifo_wr_en = out_vld_q;
  assign bus.busy       = (bcnt_q != '0) | out_vld_q | flush_pend_q;
  assign acc            = bus.in_vld & bus.in_rdy;
  // next state: drain, accept a byte, then apply a requested or pending flush to the result
  always_comb begin
    asm_d        = asm_q;
    bcnt_a       = bcnt_q;
    out_word_d   = out_word_q;
    out_vld_d    = out_vld_q & bus.fifo_full;
    flush_pend_d = flush_pend_q;
    if (acc) begin
      asm_d[DW-1-8*int'(bcnt_q) -: 8] = bus.in_dat;
      bcnt_a = (bcnt_q == LAST) ? '0 : bcnt_q + 1'b1;
      if (bcnt_q == LAST) begin
        out_word_d = asm_d;
        out_vld_d  = 1'b1;
      end
    end
    for (int i = 0; i < NB; i++)
      pad_word[DW-1-8*i -: 8] = (i < int'(bcnt_a)) ? asm_d[DW-1-8*i -: 8] : PAD;
    do_flush = (bus.flush | flush_pend_q) & (bcnt_a != '0);
    bcnt_d   = bcnt_a;
    if (do_flush & out_free) begin
      out_word_d   = pad_word;
      out_vld_d    = 1'b1;
      bcnt_d       = '0;
      flush_pend_d = 1'b0;
    end else if (do_flush) begin
      flush_pend_d = 1'b1;
    end
  end
  // state registers advance only on enabled edges; clr overrides everything else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q        <= '0;
      bcnt_q       <= '0;
      out_word_q   <= '0;
      out_vld_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else if (bus.clk7_en) begin
      if (bus.clr) begin
        bcnt_q       <= '0;
        out_vld_q    <= 1'b0;
        flush_pend_q <= 1'b0;
      end else begin
        asm_q        <= asm_d;
        bcnt_q       <= bcnt_d;
        out_word_q   <= out_word_d;
        out_vld_q    <= out_vld_d;
        flush_pend_q <= flush_pend_d;
      end
    end
  end
`ifdef PACK_OVF_CNT_EN
  logic [7:0] ovf_q, ovf_d;
  assign ovf_d       = (bus.in_vld & !bus.in_rdy & ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
  assign bus.ovf_cnt = ovf_q;
  // saturating count of bytes dropped while the packer could not take them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= '0;
    else if (bus.clk7_en) ovf_q <= bus.clr ? 8'h00 : ovf_d;
  end
`else
  assign bus.ovf_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_sync_fifo_byte_packer.sv
// tb_sync_fifo_byte_packer: vector table, corner sequences and randomized run against a queue-based reference model
module tb_sync_fifo_byte_packer;
  localparam int DW = 16;
  localparam int NB = DW / 8;
  localparam logic [7:0] PAD = 8'h00;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sync_fifo_byte_packer_if #(.DW(DW)) bus ();
  sync_fifo_byte_packer #(.DW(DW), .PAD(PAD)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] got[$];
  logic [DW-1:0] m_wr[$];
  logic [7:0]    m_part[$];
  logic          m_hv, m_pend;
  logic [DW-1:0] m_hw;
  int            m_ovf;
  typedef struct {
    logic en, clr, vld;
    logic [7:0] dat;
    logic fl, full;
    logic wr;
    logic [DW-1:0] fin;
    logic rdy, busy;
  } vec_t;
  vec_t tv[10];
  logic [DW-1:0] tbl_exp[4];
  // what the downstream FIFO actually stores
  always @(posedge clk)
    if (!rst && bus.clk7_en && bus.fifo_wr_en && !bus.fifo_full) got.push_back(bus.fifo_in);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] packed_word();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < NB; i++)
      w |= DW'(i < m_part.size() ? m_part[i] : PAD) << (DW - 8 - 8 * i);
    return w;
  endfunction
  function automatic int exp_ovf();
`ifdef PACK_OVF_CNT_EN
    return m_ovf;
`else
    return 0;
`endif
  endfunction
  task automatic m_reset();
    m_part.delete();
    m_hv = 1'b0;
    m_hw = '0;
    m_pend = 1'b0;
    m_ovf = 0;
  endtask
  task automatic m_edge();
    logic free, rdy;
    if (!bus.clk7_en) return;
    if (m_hv && !bus.fifo_full) m_wr.push_back(m_hw);
    free = !m_hv || !bus.fifo_full;
    if (bus.clr) begin
      m_part.delete();
      m_hv = 1'b0;
      m_pend = 1'b0;
      m_ovf = 0;
      return;
    end
    m_hv = m_hv && bus.fifo_full;
    rdy = !(m_pend || (m_part.size() == NB - 1 && !free));
    if (bus.in_vld) begin
      if (rdy) begin
        m_part.push_back(bus.in_dat);
        if (m_part.size() == NB) begin
          m_hw = packed_word();
          m_hv = 1'b1;
          m_part.delete();
        end
      end else if (m_ovf < 255) m_ovf++;
    end
    if ((bus.flush || m_pend) && m_part.size() != 0) begin
      if (free) begin
        m_hw = packed_word();
        m_hv = 1'b1;
        m_part.delete();
        m_pend = 1'b0;
      end else m_pend = 1'b1;
    end
  endtask
  task automatic step();
    @(posedge clk);
    if (!rst) m_edge();
    #1;
  endtask
  task automatic check_model(input string tag);
    logic free = !m_hv || !bus.fifo_full;
    chk({tag, "_in_rdy"}, bus.in_rdy, !(m_pend || (m_part.size() == NB - 1 && !free)));
    chk({tag, "_wr_en"}, bus.fifo_wr_en, m_hv);
    chk({tag, "_fifo_in"}, bus.fifo_in, m_hw);
    chk({tag, "_busy"}, bus.busy, m_part.size() != 0 || m_hv || m_pend);
    chk({tag, "_ovf"}, bus.ovf_cnt, exp_ovf());
  endtask
  task automatic drive(input logic en, input logic clr, input logic vld, input logic [7:0] dat,
                       input logic fl, input logic full);
    bus.clk7_en = en;
    bus.clr = clr;
    bus.in_vld = vld;
    bus.in_dat = dat;
    bus.flush = fl;
    bus.fifo_full = full;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    m_reset();
    got.delete();
    m_wr.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic chk_got(input string name, input int idx, input logic [DW-1:0] exp);
    chk(name, got.size() > idx ? got[idx] : 'x, exp);
  endtask
  initial begin
    int n;
    tv[0] = '{1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tv[1] = '{1'b1, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b1};
    tv[2] = '{1'b1, 1'b0, 1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b1};
    tv[3] = '{1'b1, 1'b0, 1'b1, 8'h78, 1'b0, 1'b0, 1'b1, 16'h5678, 1'b1, 1'b1};
    tv[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h5678, 1'b1, 1'b0};
    tv[5] = '{1'b1, 1'b0, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 16'h5678, 1'b1, 1'b1};
    tv[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hAB00, 1'b1, 1'b1};
    tv[7] = '{1'b1, 1'b0, 1'b1, 8'hCD, 1'b1, 1'b0, 1'b1, 16'hCD00, 1'b1, 1'b1};
    tv[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'hCD00, 1'b1, 1'b0};
    tv[9] = '{1'b0, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 16'hCD00, 1'b1, 1'b0};
    tbl_exp = '{16'h1234, 16'h5678, 16'hAB00, 16'hCD00};
    do_reset();
    chk("rst_in_rdy", bus.in_rdy, 1'b1);
    chk("rst_wr_en", bus.fifo_wr_en, 1'b0);
    chk("rst_fifo_in", bus.fifo_in, 16'h0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ovf", bus.ovf_cnt, 8'h00);
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].en, tv[i].clr, tv[i].vld, tv[i].dat, tv[i].fl, tv[i].full);
      step();
      chk($sformatf("tv%0d_wr_en", i), bus.fifo_wr_en, tv[i].wr);
      chk($sformatf("tv%0d_fifo_in", i), bus.fifo_in, tv[i].fin);
      chk($sformatf("tv%0d_in_rdy", i), bus.in_rdy, tv[i].rdy);
      chk($sformatf("tv%0d_busy", i), bus.busy, tv[i].busy);
    end
    chk("tbl_nwrites", got.size(), 4);
    for (int i = 0; i < 4; i++) chk_got($sformatf("tbl_write%0d", i), i, tbl_exp[i]);
    // drop while full, then held word drains
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1); step();
    bus.in_dat = 8'h22; step();
    bus.in_dat = 8'h33; step();
    bus.in_vld = 1'b0; #1;
    chk("drop_in_rdy_low", bus.in_rdy, 1'b0);
    bus.in_vld = 1'b1; bus.in_dat = 8'hEE; step();
`ifdef PACK_OVF_CNT_EN
    chk("drop_ovf", bus.ovf_cnt, 8'd1);
`else
    chk("drop_ovf", bus.ovf_cnt, 8'd0);
`endif
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); step();
    chk("drop_nwrites", got.size(), 1);
    chk_got("drop_held_word", 0, 16'h1122);
    chk("drop_wr_en_after", bus.fifo_wr_en, 1'b0);
    chk("drop_busy_partial", bus.busy, 1'b1);
    // flush while the output register is blocked
    drive(1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1); step();
    bus.in_dat = 8'h55; step();
    bus.in_vld = 1'b0; bus.flush = 1'b1; step();
    bus.flush = 1'b0; #1;
    chk("pend_in_rdy", bus.in_rdy, 1'b0);
    chk("pend_busy", bus.busy, 1'b1);
    chk("pend_held", bus.fifo_in, 16'h3344);
    bus.in_vld = 1'b1; bus.in_dat = 8'h66; step();
    check_model("pend_drop");
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); step();
    chk("pend_nwrites1", got.size(), 2);
    chk_got("pend_held_written", 1, 16'h3344);
    chk("pend_pad_loaded_wr", bus.fifo_wr_en, 1'b1);
    chk("pend_pad_loaded", bus.fifo_in, 16'h5500);
    step();
    chk("pend_nwrites2", got.size(), 3);
    chk_got("pend_pad_written", 2, 16'h5500);
    chk("pend_idle_busy", bus.busy, 1'b0);
    check_model("pend_end");
    // saturation of the drop counter and clr
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1); step();
    bus.in_dat = 8'h02; step();
    bus.in_dat = 8'h03; step();
    repeat (300) begin
      bus.in_dat = 8'($urandom);
      step();
    end
`ifdef PACK_OVF_CNT_EN
    chk("sat_ovf", bus.ovf_cnt, 8'hFF);
`else
    chk("sat_ovf", bus.ovf_cnt, 8'h00);
`endif
    bus.clr = 1'b1; step();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); #1;
    chk("clr_ovf", bus.ovf_cnt, 8'h00);
    chk("clr_busy", bus.busy, 1'b0);
    chk("clr_wr_en", bus.fifo_wr_en, 1'b0);
    // asynchronous reset mid-word with a held word
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b1); step();
    bus.in_dat = 8'h0B; step();
    bus.in_dat = 8'h0C; step();
    bus.in_vld = 1'b0;
    chk("pre_rst_busy", bus.busy, 1'b1);
    chk("pre_rst_wr_en", bus.fifo_wr_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wr_en", bus.fifo_wr_en, 1'b0);
    chk("async_rst_fifo_in", bus.fifo_in, 16'h0000);
    chk("async_rst_in_rdy", bus.in_rdy, 1'b1);
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_ovf", bus.ovf_cnt, 8'h00);
    m_reset();
    n = got.size();
    @(negedge clk);
    rst = 1'b0;
    bus.fifo_full = 1'b0;
    repeat (3) step();
    chk("rst_no_write", got.size(), n);
    // randomized run against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
            8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 4);
      step();
      check_model($sformatf("rnd%0d", i));
    end
    chk("rnd_nwrites", got.size(), m_wr.size());
    n = 0;
    for (int i = 0; i < m_wr.size() && i < got.size(); i++) if (got[i] !== m_wr[i]) n++;
    chk("rnd_write_data_mismatches", n, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
